mainfsm: RTL and testbench

Multicycle MIPS main controller: a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback, driving datapath enables and multiplexer selects. It is the producer of `aluop`, which `aludec` turns into `alucontrol`. It sits in the controller beside `aludec`, takes `op` from the instruction register, and covers lw, sw, R-type, beq, addi, j and andi.

---
 rtl/mips_pkg.sv | 17 +
 rtl/mainfsm.sv | 110 +++++++++++
 tb/tb_mainfsm.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, control encodings and main FSM states shared by the MIPS controller.
package mips_pkg;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_FUNCT} aluop_t;
  typedef enum logic [1:0] {SRCB_B, SRCB_FOUR, SRCB_IMM, SRCB_BRANCH} alusrcb_t;
  typedef enum logic [1:0] {PC_ALURES, PC_ALUOUT, PC_JUMP, PC_RSVD} pcsrc_t;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE,
    ALUWB, BRANCH, ADDIEX, ANDIEX, IWB, JUMP
  } state_t;
endpackage

// File: rtl/mainfsm.sv
// mainfsm: multicycle MIPS main controller, Moore FSM driving datapath enables and selects.
module mainfsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       pcwrite,
  output logic       branch,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroext,
  output logic [1:0] pcsrc,
  output logic [1:0] aluop
);
  state_t state, next;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else state <= next;
  // unreachable encodings fall to the default: all outputs 0, back to FETCH
  always_comb begin
    next = FETCH;
    pcwrite = 1'b0;
    branch = 1'b0;
    iord = 1'b0;
    memwrite = 1'b0;
    irwrite = 1'b0;
    regdst = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca = 1'b0;
    alusrcb = SRCB_B;
    zeroext = 1'b0;
    pcsrc = PC_ALURES;
    aluop = ALU_ADD;
    case (state)
      FETCH: begin
        next = DECODE;
        irwrite = 1'b1;
        pcwrite = 1'b1;
        alusrcb = SRCB_FOUR;
      end
      DECODE: begin
        next = (op == OP_LW || op == OP_SW) ? MEMADR :
               (op == OP_RTYPE) ? EXECUTE :
               (op == OP_BEQ)   ? BRANCH :
               (op == OP_ADDI)  ? ADDIEX :
               (op == OP_ANDI)  ? ANDIEX :
               (op == OP_J)     ? JUMP : FETCH;
        alusrcb = SRCB_BRANCH;
      end
      MEMADR: begin
        next = (op == OP_LW) ? MEMRD : MEMWR;
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      MEMRD: begin
        next = MEMWB;
        iord = 1'b1;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        iord = 1'b1;
        memwrite = 1'b1;
      end
      EXECUTE: begin
        next = ALUWB;
        alusrca = 1'b1;
        aluop = ALU_FUNCT;
      end
      ALUWB: begin
        regdst = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        branch = 1'b1;
        pcsrc = PC_ALUOUT;
        aluop = ALU_SUB;
      end
      ADDIEX: begin
        next = IWB;
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      ANDIEX: begin
        next = IWB;
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        zeroext = 1'b1;
        aluop = ALU_AND;
      end
      IWB: regwrite = 1'b1;
      JUMP: begin
        pcwrite = 1'b1;
        pcsrc = PC_JUMP;
      end
      default: next = FETCH;
    endcase
  end
endmodule

// File: tb/tb_mainfsm.sv
// tb_mainfsm: scoreboard bench, expected per-cycle control words queued per instruction.
module tb_mainfsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] op = 6'b100011;
  logic pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, zeroext;
  logic [1:0] alusrcb, pcsrc, aluop;
  logic [15:0] obs;
  int errors = 0;
  int checks = 0;
  typedef struct {
    string tag;
    logic [15:0] w;
  } exp_t;
  exp_t sb[$];
  logic [15:0] e_fetch, e_decode, e_memadr, e_memrd, e_memwb, e_memwr, e_exec, e_aluwb;
  logic [15:0] e_branch, e_addiex, e_andiex, e_iwb, e_jump;
  mainfsm dut (
    .clk(clk), .reset(reset), .op(op), .pcwrite(pcwrite), .branch(branch), .iord(iord),
    .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .zeroext(zeroext),
    .pcsrc(pcsrc), .aluop(aluop)
  );
  always #5 clk = ~clk;
  assign obs = {pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
                alusrca, alusrcb, zeroext, pcsrc, aluop};
  function automatic logic [15:0] mk(bit pcw, bit br, bit ia, bit mw, bit irw, bit rd,
                                     bit m2r, bit rw, bit sa, logic [1:0] sb_, bit ze,
                                     logic [1:0] ps, logic [1:0] ao);
    return {pcw, br, ia, mw, irw, rd, m2r, rw, sa, sb_, ze, ps, ao};
  endfunction
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push(input string tag, input logic [15:0] w);
    exp_t e;
    e.tag = tag;
    e.w = w;
    sb.push_back(e);
  endtask
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs, e.w);
      @(negedge clk);
    end
  endtask
  task automatic run(input string name, input logic [5:0] o);
    op = o;
    push({name, "_fetch"}, e_fetch);
    push({name, "_decode"}, e_decode);
    case (o)
      6'b100011: begin
        push({name, "_memadr"}, e_memadr);
        push({name, "_memrd"}, e_memrd);
        push({name, "_memwb"}, e_memwb);
      end
      6'b101011: begin
        push({name, "_memadr"}, e_memadr);
        push({name, "_memwr"}, e_memwr);
      end
      6'b000000: begin
        push({name, "_exec"}, e_exec);
        push({name, "_aluwb"}, e_aluwb);
      end
      6'b000100: push({name, "_branch"}, e_branch);
      6'b001000: begin
        push({name, "_addiex"}, e_addiex);
        push({name, "_iwb"}, e_iwb);
      end
      6'b001100: begin
        push({name, "_andiex"}, e_andiex);
        push({name, "_iwb"}, e_iwb);
      end
      6'b000010: push({name, "_jump"}, e_jump);
      default: ;
    endcase
    drain();
  endtask
  initial begin
    e_fetch  = mk(1,0,0,0,1,0,0,0,0,2'b01,0,2'b00,2'b00);
    e_decode = mk(0,0,0,0,0,0,0,0,0,2'b11,0,2'b00,2'b00);
    e_memadr = mk(0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,2'b00);
    e_memrd  = mk(0,0,1,0,0,0,0,0,0,2'b00,0,2'b00,2'b00);
    e_memwb  = mk(0,0,0,0,0,0,1,1,0,2'b00,0,2'b00,2'b00);
    e_memwr  = mk(0,0,1,1,0,0,0,0,0,2'b00,0,2'b00,2'b00);
    e_exec   = mk(0,0,0,0,0,0,0,0,1,2'b00,0,2'b00,2'b11);
    e_aluwb  = mk(0,0,0,0,0,1,0,1,0,2'b00,0,2'b00,2'b00);
    e_branch = mk(0,1,0,0,0,0,0,0,1,2'b00,0,2'b01,2'b01);
    e_addiex = mk(0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,2'b00);
    e_andiex = mk(0,0,0,0,0,0,0,0,1,2'b10,1,2'b00,2'b10);
    e_iwb    = mk(0,0,0,0,0,0,0,1,0,2'b00,0,2'b00,2'b00);
    e_jump   = mk(1,0,0,0,0,0,0,0,0,2'b00,0,2'b10,2'b00);
    #1 check("rst_async_t0", obs, e_fetch);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_hold%0d", i), obs, e_fetch);
    end
    reset = 1'b0;
    run("lw", 6'b100011);
    run("andi", 6'b001100);
    run("rtype", 6'b000000);
    run("beq", 6'b000100);
    run("sw", 6'b101011);
    run("j", 6'b000010);
    run("unk", 6'b111111);
    run("addi", 6'b001000);
    op = 6'b101011;
    push("sw2_fetch", e_fetch);
    push("sw2_decode", e_decode);
    push("sw2_memadr", e_memadr);
    drain();
    check("sw2_memwr", obs, e_memwr);
    #2 reset = 1'b1;
    #1 check("rst_mid_memwr", obs, e_fetch);
    @(negedge clk);
    check("rst_mid_hold", obs, e_fetch);
    reset = 1'b0;
    run("lw_after", 6'b100011);
    run("rtype_after", 6'b000000);
    check("final_fetch", obs, e_fetch);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
